// File: rtl/pci_irq_requester.sv
// rtl/pci_irq_requester.sv - edge-capturing interrupt requester for the PCI bridge
// Tracks the bridge's two-pulse IRQ_ACK handshake with per-pulse timeout and a post-service holdoff.
module pci_irq_requester #(
  parameter int NUM_SOURCES    = 4,
  parameter int ACK_TIMEOUT    = 100,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_SOURCES-1:0] irq_src,
  input  logic [NUM_SOURCES-1:0] irq_mask,
  input  logic                   IRQ_ACK,
  output logic                   IRQ_REQ,
  output logic [NUM_SOURCES-1:0] irq_vector,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   timeout_count
);

  localparam int TMAX = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_ACK  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_HOLD = TW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [NUM_SOURCES-1:0] pending, pending_n;
  logic [NUM_SOURCES-1:0] src_prev;
  logic [NUM_SOURCES-1:0] edges, eligible;
  logic [NUM_SOURCES-1:0] vec_n;
  logic [TW-1:0]          timer, timer_n;
  logic                   req_n;
  logic [CNT_WIDTH-1:0]   cnt_n;
  logic                   cnt_sat;

  assign edges    = irq_src & ~src_prev & ~irq_mask;
  assign eligible = pending & ~irq_mask;
  assign cnt_sat  = &timeout_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      pending       <= '0;
      src_prev      <= '0;
      timer         <= '0;
      IRQ_REQ       <= 1'b0;
      irq_vector    <= '0;
      busy          <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      src_prev      <= irq_src;
      timer         <= timer_n;
      IRQ_REQ       <= req_n;
      irq_vector    <= vec_n;
      busy          <= (state_n != IDLE);
      timeout_count <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending | edges;
    timer_n   = timer;
    req_n     = IRQ_REQ;
    vec_n     = irq_vector;
    cnt_n     = timeout_count;
    case (state)
      IDLE: begin
        // Fresh edges are OR'd back in after the clear so a same-cycle edge stays pending.
        if (|eligible) begin
          vec_n     = eligible;
          pending_n = (pending & ~eligible) | edges;
          req_n     = 1'b1;
          timer_n   = T_ACK;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (IRQ_ACK) begin
          req_n   = 1'b0;
          timer_n = T_ACK;
          state_n = SERVICE;
        end else if (timer == '0) begin
          req_n     = 1'b0;
          pending_n = pending | edges | irq_vector;
          vec_n     = '0;
          if (!cnt_sat) cnt_n = timeout_count + CNT_WIDTH'(1);
          timer_n   = T_HOLD;
          state_n   = HOLDOFF;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      SERVICE: begin
        // Delivery was already accepted, so a service timeout is counted but not re-queued.
        if (IRQ_ACK || timer == '0) begin
          vec_n   = '0;
          timer_n = T_HOLD;
          state_n = HOLDOFF;
          if (!IRQ_ACK && !cnt_sat) cnt_n = timeout_count + CNT_WIDTH'(1);
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      HOLDOFF: begin
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pci_irq_requester.sv
// tb/tb_pci_irq_requester.sv - table, directed and randomized checks of pci_irq_requester
// The reference model tracks phase and elapsed cycles per phase, counting upward.
module tb_pci_irq_requester;

  localparam int NS   = 4;
  localparam int AT   = 8;
  localparam int HO   = 2;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NS-1:0] irq_src, irq_mask;
  logic          IRQ_ACK;
  logic          IRQ_REQ;
  logic [NS-1:0] irq_vector;
  logic          busy;
  logic [CW-1:0] timeout_count;

  pci_irq_requester #(
    .NUM_SOURCES(NS), .ACK_TIMEOUT(AT), .HOLDOFF_CYCLES(HO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .irq_src(irq_src), .irq_mask(irq_mask),
    .IRQ_ACK(IRQ_ACK), .IRQ_REQ(IRQ_REQ), .irq_vector(irq_vector),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // phase: 0 idle, 1 awaiting accept, 2 awaiting service, 3 quiet period
  logic [NS-1:0] m_pend, m_prev, m_vec;
  int            m_phase, m_age, m_cnt;

  function automatic void model_reset();
    m_pend = '0; m_prev = '0; m_vec = '0;
    m_phase = 0; m_age = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic [NS-1:0] s, input logic [NS-1:0] m, input logic a);
    logic [NS-1:0] e, elig;
    e = s & ~m_prev & ~m;
    m_prev = s;
    elig = m_pend & ~m;
    m_pend = m_pend | e;
    case (m_phase)
      0: if (elig != 0) begin
        m_vec = elig;
        m_pend = (m_pend & ~elig) | e;
        m_phase = 1; m_age = 0;
      end
      1: if (a) begin
        m_phase = 2; m_age = 0;
      end else if (m_age == AT - 1) begin
        m_pend = m_pend | m_vec;
        m_vec = '0;
        if (m_cnt < CMAX) m_cnt++;
        m_phase = 3; m_age = 0;
      end else m_age++;
      2: if (a || m_age == AT - 1) begin
        if (!a && m_cnt < CMAX) m_cnt++;
        m_vec = '0;
        m_phase = 3; m_age = 0;
      end else m_age++;
      default: if (m_age == HO) m_phase = 0; else m_age++;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("m_req", 32'(IRQ_REQ), 32'(m_phase == 1));
    check("m_vec", 32'(irq_vector), 32'(m_vec));
    check("m_busy", 32'(busy), 32'(m_phase != 0));
    check("m_cnt", 32'(timeout_count), 32'(m_cnt));
  endtask

  task automatic tick(input logic [NS-1:0] s, input logic [NS-1:0] m, input logic a);
    irq_src = s; irq_mask = m; IRQ_ACK = a;
    @(posedge clk);
    model_step(s, m, a);
    #1;
  endtask

  task automatic tick_chk(input logic [NS-1:0] s, input logic [NS-1:0] m, input logic a);
    tick(s, m, a);
    check_model();
  endtask

  task automatic do_reset();
    resetn = 1'b0; irq_src = '0; irq_mask = '0; IRQ_ACK = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [NS-1:0] src;
    logic [NS-1:0] mask;
    logic          ack;
    logic          req;
    logic [NS-1:0] vec;
    logic          bsy;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NS-1:0] s, m;

    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    for (int i = 2; i <= 6; i++) tbl[i] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd0};
    tbl[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[16] = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[17] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[19] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[20] = '{4'b0100, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd0};

    resetn = 1'b0; irq_src = '0; irq_mask = '0; IRQ_ACK = 1'b0;
    #1;
    check("rst_req", 32'(IRQ_REQ), 32'd0);
    check("rst_vec", 32'(irq_vector), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(timeout_count), 32'd0);
    do_reset();

    // single source handshake followed by mask handling
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].src, tbl[i].mask, tbl[i].ack);
      check($sformatf("tbl%0d_req", i), 32'(IRQ_REQ), 32'(tbl[i].req));
      check($sformatf("tbl%0d_vec", i), 32'(irq_vector), 32'(tbl[i].vec));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("tbl%0d_cnt", i), 32'(timeout_count), 32'(tbl[i].cnt));
    end

    // coalesce edges arriving during SERVICE
    do_reset();
    tick_chk(4'b0001, '0, 1'b0);
    tick_chk(4'b0001, '0, 1'b0);
    check("coal_vec1", 32'(irq_vector), 32'b0001);
    repeat (3) tick_chk(4'b0001, '0, 1'b0);
    tick_chk(4'b0001, '0, 1'b1);
    tick_chk(4'b1101, '0, 1'b0);
    repeat (3) tick_chk(4'b1101, '0, 1'b0);
    tick_chk(4'b1101, '0, 1'b1);
    n = 0;
    for (int i = 0; i < 10 && !IRQ_REQ; i++) begin
      tick_chk(4'b1101, '0, 1'b0);
      n++;
    end
    check("coal_gap", 32'(n), 32'd4);
    check("coal_vec2", 32'(irq_vector), 32'b1100);

    // ack timeout, reissue and counter saturation
    do_reset();
    tick_chk(4'b1000, '0, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick_chk(4'b1000, '0, 1'b0);
      if (IRQ_REQ) n++;
      else if (n > 0) break;
    end
    check("to_req_len", 32'(n), 32'd8);
    check("to_cnt1", 32'(timeout_count), 32'd1);
    for (int i = 0; i < 10 && !IRQ_REQ; i++) tick_chk(4'b1000, '0, 1'b0);
    check("to_reissue", 32'(IRQ_REQ), 32'd1);
    check("to_reissue_vec", 32'(irq_vector), 32'b1000);
    repeat (40) tick_chk(4'b1000, '0, 1'b0);
    check("to_sat", 32'(timeout_count), 32'd3);

    // ACK on the exact expiry cycle, then an edge during the IDLE snapshot cycle
    do_reset();
    tick_chk(4'b0001, '0, 1'b0);
    tick_chk(4'b0001, '0, 1'b0);
    repeat (7) tick_chk(4'b0001, '0, 1'b0);
    tick_chk(4'b0001, '0, 1'b1);
    check("sim_req", 32'(IRQ_REQ), 32'd0);
    check("sim_vec", 32'(irq_vector), 32'b0001);
    check("sim_busy", 32'(busy), 32'd1);
    check("sim_cnt", 32'(timeout_count), 32'd0);
    tick_chk(4'b0001, '0, 1'b1);
    tick_chk(4'b0011, '0, 1'b0);
    tick_chk(4'b0001, '0, 1'b0);
    for (int i = 0; i < 10 && busy; i++) tick_chk(4'b0001, '0, 1'b0);
    tick_chk(4'b0011, '0, 1'b0);
    check("snap_vec", 32'(irq_vector), 32'b0010);
    tick_chk(4'b0011, '0, 1'b1);
    tick_chk(4'b0011, '0, 1'b1);
    for (int i = 0; i < 10 && !IRQ_REQ; i++) tick_chk(4'b0011, '0, 1'b0);
    check("snap_reissue", 32'(IRQ_REQ), 32'd1);
    check("snap_reissue_vec", 32'(irq_vector), 32'b0010);

    // asynchronous reset during SERVICE, then a stray ACK
    do_reset();
    tick_chk(4'b0100, '0, 1'b0);
    tick_chk(4'b0100, '0, 1'b0);
    tick_chk(4'b0100, '0, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    irq_src = '0;
    #1;
    check("arst_req", 32'(IRQ_REQ), 32'd0);
    check("arst_vec", 32'(irq_vector), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt", 32'(timeout_count), 32'd0);
    @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    tick_chk(4'b0000, '0, 1'b1);
    repeat (3) tick_chk(4'b0000, '0, 1'b0);
    check("stray_ack_idle", 32'(busy), 32'd0);

    // randomized traffic against the model
    do_reset();
    s = '0; m = '0;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 3) == 0) s[b] = ~s[b];
      if ($urandom_range(0, 15) == 0) m = NS'($urandom_range(0, 15));
      tick_chk(s, m, ($urandom_range(0, 5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pci_irq_requester.md
Name: pci_irq_requester

Overview:
- Upstream neighbour of the PCI bridge interrupt interface.
- Collects NUM_SOURCES edge-triggered interrupt sources into a pending register and snapshots them into a vector.
- Drives a level IRQ_REQ to the bridge, then tracks the bridge's two-pulse IRQ_ACK protocol: first pulse = accepted, second pulse = serviced.
- Provides ack timeout/retry, a post-service holdoff, and a saturating timeout counter.

Parameters:
- NUM_SOURCES, 4: number of interrupt source inputs.
- ACK_TIMEOUT, 100: cycles to wait for each IRQ_ACK pulse before declaring a timeout (must be >= 1).
- HOLDOFF_CYCLES, 2: idle cycles enforced after each request completes (0 allowed).
- CNT_WIDTH, 16: width of timeout_count.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- irq_src  in  NUM_SOURCES  interrupt sources; a rising edge requests an interrupt
- irq_mask  in  NUM_SOURCES  1 = source disabled
- IRQ_ACK  in  1  single-cycle pulses from the bridge
- IRQ_REQ  out  1  level interrupt request to the bridge
- irq_vector  out  NUM_SOURCES  sources covered by the in-flight request
- busy  out  1  high in every state other than IDLE
- timeout_count  out  CNT_WIDTH  saturating count of ack timeouts

Behaviour:
- Reset is asynchronous and active-low. While resetn = 0:
  - IRQ_REQ = 0, irq_vector = 0, busy = 0, timeout_count = 0.
  - pending = 0, src_prev = 0, timer = 0, state = IDLE.
  - Reset mid-request drops the request with no further ACK tracking.
- Edge capture:
  - src_prev registers irq_src every cycle.
  - Each cycle, pending |= irq_src & ~src_prev & ~irq_mask.
  - Masked edges are discarded.
  - Masking a bit that is already pending does not clear it, but IDLE ignores that bit while it is masked.
- eligible = pending & ~irq_mask.
- Latency: src sampled high (prev low) at edge k → pending set at k → IRQ_REQ high after edge k+1.
- State IDLE:
  - If eligible != 0: irq_vector <= eligible, pending clears those bits, IRQ_REQ <= 1, timer <= ACK_TIMEOUT-1, go to REQ.
  - If a new edge arrives on a bit in the same cycle it is being snapshotted, that edge wins: the bit stays pending.
- State REQ (IRQ_REQ held high):
  - If IRQ_ACK: IRQ_REQ <= 0, timer <= ACK_TIMEOUT-1, go to SERVICE.
  - Else if timer == 0: IRQ_REQ <= 0, pending |= irq_vector (re-queue), irq_vector <= 0, timeout_count++ (saturating at all-ones), timer <= HOLDOFF_CYCLES, go to HOLDOFF.
  - Else timer--.
- State SERVICE (IRQ_REQ low, irq_vector held):
  - If IRQ_ACK: irq_vector <= 0, timer <= HOLDOFF_CYCLES, go to HOLDOFF.
  - Else if timer == 0: same as the ACK case, plus timeout_count++ (saturating). No re-queue, because delivery was already accepted.
  - Else timer--.
- State HOLDOFF:
  - If timer == 0, go to IDLE; else timer--.
  - So HOLDOFF_CYCLES = 0 gives exactly one HOLDOFF cycle.
- IRQ_ACK arriving in IDLE or HOLDOFF is ignored.
- An IRQ_ACK and a timer expiry in the same cycle: ACK wins, no count increment.
- Edge capture continues in every state. New edges during REQ/SERVICE/HOLDOFF accumulate in pending and are serviced by the next request (coalesced).
- busy = (state != IDLE), registered.

Test Plan:
- Single source: bridge model acks 5 cycles after sampling REQ and again 5 cycles later; irq_src[1] rises → IRQ_REQ high 2 cycles later, irq_vector = 4'b0010; IRQ_REQ falls the cycle after the first ACK; irq_vector clears after the second ACK; busy low HOLDOFF_CYCLES+1 cycles later; timeout_count = 0.
- Coalesce: irq_src[0] rises, then irq_src[2] and irq_src[3] rise while in SERVICE → first vector 4'b0001, second request vector 4'b1100 issued right after HOLDOFF.
- Mask: irq_mask = 4'b0100, pulse irq_src[2] → no IRQ_REQ. Unmask, no new edge → still no request. Pulse again → vector 4'b0100.
- Ack timeout: ACK_TIMEOUT = 8, bridge never acks, irq_src[3] rises → IRQ_REQ high exactly 8 cycles, timeout_count = 1, request reissued with 4'b1000 after holdoff. Repeat until timeout_count saturates (CNT_WIDTH = 2 → stays at 3).
- Simultaneity: IRQ_ACK on the exact expiry cycle in REQ → enters SERVICE, timeout_count unchanged. New edge on a bit in the IDLE snapshot cycle → that bit is reissued in the next request.
- Reset mid-operation: resetn low during SERVICE → all outputs 0 immediately (asynchronously). After release, a stray IRQ_ACK is ignored and the block stays IDLE.
